serial_subtractor: RTL and testbench



---
 rtl/serial_arith_pkg.sv | 18 +
 rtl/fullsubtractor.sv | 13 +
 rtl/serial_subtractor.sv | 132 +++++++++++++
 tb/tb_serial_subtractor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// the legal operand-width range.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned WIDTH_MIN = 32'd1;
  localparam int unsigned WIDTH_MAX = 32'd32;

  function automatic logic width_ok(input int unsigned w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/fullsubtractor.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow-out.
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor computing a - b - bin over WIDTH cycles,
// using a single full-subtractor cell and a borrow flop.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("serial_subtractor: WIDTH out of range 1..32");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cell_d_s, cell_bout_s;
  logic             accept_s, last_s;
  logic [WIDTH-1:0] res_shift_s;

  fullsubtractor u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (cell_d_s),
    .bout (cell_bout_s)
  );

  // Next-state, datapath shifting and output-register update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;

    accept_s    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    last_s      = (cnt_q == CW'(WIDTH - 1));
    // New bit enters at the MSB; written this way so WIDTH=1 needs no special case.
    res_shift_s = (res_q >> 1) | (WIDTH'(cell_d_s) << (WIDTH - 1));

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_d  = ST_RUN;
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          cnt_d    = '0;
          res_d    = '0;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_d    = res_shift_s;
        borrow_d = cell_bout_s;
        cnt_d    = cnt_q + CW'(1);
        if (last_s) begin
          state_d = ST_DONE;
          diff_d  = res_shift_s;
          bout_d  = cell_bout_s;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, corner sequences,
// randomized operations against an arithmetic model, and an exhaustive WIDTH=1 run.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic       bin = 1'b0;
  logic       busy, done, bout;
  logic [7:0] diff;

  logic       start1 = 1'b0;
  logic [0:0] a1 = 1'b0, b1 = 1'b0;
  logic       bin1 = 1'b0;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic; a negative result means a borrow out.
  function automatic logic [8:0] model(input int w, input int x, input int y, input int r);
    int d;
    d = x - y - r;
    return {(d < 0), 8'(d & ((1 << w) - 1))};
  endfunction

  // Accept one operation, then run until done (bounded). Optionally pokes a
  // conflicting start at cycle 'poke' after acceptance.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                       input int poke, output int lat, output int bcnt, output bit held);
    logic [7:0] d0;
    logic       b0;
    d0 = diff;
    b0 = bout;
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    lat = 0; bcnt = 0; held = 1'b1;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (diff !== d0 || bout !== b0) held = 1'b0;
      start = (lat == poke);
      if (lat == poke) begin
        a = 8'h00; b = 8'hFF;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, bcnt;
    bit held;
    logic [8:0] m;

    tbl[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0};
    tbl[1] = '{8'h12, 8'h35, 1'b0, 8'hDD, 1'b1};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    tbl[5] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1};

    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].bin, -1, lat, bcnt, held);
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd8);
      check($sformatf("tbl%0d_busy_cycles", i), 32'(bcnt), 32'd8);
      check($sformatf("tbl%0d_diff", i), 32'(diff), 32'(tbl[i].diff));
      check($sformatf("tbl%0d_bout", i), 32'(bout), 32'(tbl[i].bout));
      check($sformatf("tbl%0d_hold", i), 32'(held), 32'd1);
      @(posedge clk); #1;
      check($sformatf("tbl%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // Start during RUN must be ignored; then back-to-back from the DONE cycle.
    do_op(8'h80, 8'h01, 1'b0, 2, lat, bcnt, held);
    check("ign_latency", 32'(lat), 32'd8);
    check("ign_diff", 32'(diff), 32'h7F);
    check("ign_bout", 32'(bout), 32'd0);
    check("ign_hold", 32'(held), 32'd1);
    do_op(8'h10, 8'h20, 1'b0, -1, lat, bcnt, held);
    check("b2b_done_gap", 32'(lat + 1), 32'd9);
    check("b2b_busy_cycles", 32'(bcnt), 32'd8);
    check("b2b_diff", 32'(diff), 32'hF0);
    check("b2b_bout", 32'(bout), 32'd1);
    check("b2b_hold", 32'(held), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 30; i++) begin
      logic [7:0] ra, rb;
      logic       rr;
      ra = 8'($urandom); rb = 8'($urandom); rr = 1'($urandom);
      m = model(8, int'(ra), int'(rb), int'(rr));
      do_op(ra, rb, rr, -1, lat, bcnt, held);
      check("rnd_latency", 32'(lat), 32'd8);
      check($sformatf("rnd_diff %0h-%0h-%0h", ra, rb, rr), 32'(diff), 32'(m[7:0]));
      check($sformatf("rnd_bout %0h-%0h-%0h", ra, rb, rr), 32'(bout), 32'(m[8]));
      if (i % 3 == 0) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;

    // Asynchronous reset mid-RUN aborts and clears outputs immediately.
    do_op(8'hC3, 8'h12, 1'b0, -1, lat, bcnt, held);
    a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_diff", 32'(diff), 32'd0);
    check("arst_bout", 32'(bout), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("arst_idle_busy", 32'(busy), 32'd0);
    check("arst_no_done", 32'(done), 32'd0);
    do_op(8'h05, 8'h03, 1'b0, -1, lat, bcnt, held);
    check("arst_after_latency", 32'(lat), 32'd8);
    check("arst_after_diff", 32'(diff), 32'h02);
    check("arst_after_bout", 32'(bout), 32'd0);
    @(posedge clk); #1;

    // WIDTH=1: exhaustive truth table, done one cycle after acceptance.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; bin1 = v[0];
      m = model(1, int'(v[2]), int'(v[1]), int'(v[0]));
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      check($sformatf("w1_%0d_busy", i), 32'(busy1), 32'd1);
      check($sformatf("w1_%0d_early_done", i), 32'(done1), 32'd0);
      @(posedge clk); #1;
      check($sformatf("w1_%0d_done", i), 32'(done1), 32'd1);
      check($sformatf("w1_%0d_diff", i), 32'(diff1), 32'(m[0]));
      check($sformatf("w1_%0d_bout", i), 32'(bout1), 32'(m[8]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
